// File: rtl/das_pkg.sv
// Shared types and default widths for the DAS scan-line capture block.
package das_pkg;

   localparam int unsigned DAS_DATA_W = 32;
   localparam int unsigned DAS_ADDR_W = 10;
   localparam int unsigned DAS_CNT_W  = 16;

   // One AXI4-Stream beat as seen by the capture sink.
   typedef struct packed {
      logic [DAS_DATA_W-1:0] data;
      logic                  last;
   } axis_beat_t;

   // Sample count of a stored line, 1..DEPTH, hence one bit wider than an address.
   typedef logic [DAS_ADDR_W:0] line_len_t;

   // Write-side mode: store beats, or discard the tail of an over-long line.
   typedef enum logic {
      WR_CAPTURE = 1'b0,
      WR_DROP    = 1'b1
   } wr_state_e;

endpackage

// File: rtl/das_pingpong_ram.sv
// Two-bank simple dual-port RAM; the bank select is the address MSB.
module das_pingpong_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W:0]   i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W:0]   i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned WORDS = 2 << ADDR_W;

   logic [DATA_W-1:0] r_mem [WORDS];

   // Write port: storage itself is never reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: one-cycle registered read, output register cleared on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rdata <= '0;
      end else begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/das_line_capture.sv
// AXI4-Stream sink capturing tlast-delimited scan lines into a ping-pong buffer.
module das_line_capture
   import das_pkg::*;
#(
   parameter int unsigned DATA_W = DAS_DATA_W,
   parameter int unsigned ADDR_W = DAS_ADDR_W,
   parameter int unsigned CNT_W  = DAS_CNT_W
) (
   input  logic              s00_axis_aclk,
   input  logic              s00_axis_aresetn,
   input  logic [DATA_W-1:0] s00_axis_tdata,
   input  logic              s00_axis_tvalid,
   input  logic              s00_axis_tlast,
   output logic              s00_axis_tready,
   output logic              line_valid,
   output logic [ADDR_W:0]   line_len,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              line_done,
   output logic [CNT_W-1:0]  line_count,
   output logic              err_overflow,
   input  logic              err_clear
);

   logic              r_run;
   wr_state_e         r_state;
   logic              r_wr_bank;
   logic              r_rd_bank;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [1:0]        r_full;
   logic [ADDR_W:0]   r_len [2];
   logic [CNT_W-1:0]  r_line_count;
   logic              r_err;

   logic              w_accept;
   logic              w_store;
   logic              w_at_end;
   logic              w_close;
   logic              w_overrun;
   logic              w_release;
   logic [1:0]        w_full_nxt;

   // Dropping beats is always allowed so an over-long line can drain.
   assign s00_axis_tready = r_run & ((r_state == WR_DROP) | ~r_full[r_wr_bank]);
   assign w_accept        = s00_axis_tvalid & s00_axis_tready;
   assign w_store         = w_accept & (r_state == WR_CAPTURE);
   assign w_at_end        = &r_wr_addr;
   assign w_close         = w_store & (s00_axis_tlast | w_at_end);
   assign w_overrun       = w_store & w_at_end & ~s00_axis_tlast;
   assign w_release       = line_done & r_full[r_rd_bank];

   assign line_valid   = r_full[r_rd_bank];
   assign line_len     = r_len[r_rd_bank];
   assign line_count   = r_line_count;
   assign err_overflow = r_err;

   // Close and release always target opposite banks, so both apply together.
   always_comb begin
      w_full_nxt = r_full;
      if (w_close) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_release) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   // Hold off the stream for the first cycle after reset release.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // Write FSM: fill the write bank, close lines, drop the tail of long lines.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_state      <= WR_CAPTURE;
         r_wr_bank    <= 1'b0;
         r_wr_addr    <= '0;
         r_len[0]     <= '0;
         r_len[1]     <= '0;
         r_line_count <= '0;
      end else begin
         case (r_state)
            WR_CAPTURE: begin
               if (w_close) begin
                  r_len[r_wr_bank] <= {1'b0, r_wr_addr} + (ADDR_W+1)'(1);
                  r_wr_bank        <= ~r_wr_bank;
                  r_wr_addr        <= '0;
                  r_line_count     <= r_line_count + CNT_W'(1);
                  if (w_overrun) begin
                     r_state <= WR_DROP;
                  end
               end else if (w_store) begin
                  r_wr_addr <= r_wr_addr + ADDR_W'(1);
               end
            end
            WR_DROP: begin
               if (w_accept && s00_axis_tlast) begin
                  r_state <= WR_CAPTURE;
               end
            end
            default: r_state <= WR_CAPTURE;
         endcase
      end
   end

   // Bank occupancy and read-bank pointer.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_full    <= 2'b00;
         r_rd_bank <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (w_release) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   // Sticky overflow flag; a clear wins over a same-cycle set.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_err <= 1'b0;
      end else if (err_clear) begin
         r_err <= 1'b0;
      end else if (w_overrun) begin
         r_err <= 1'b1;
      end
   end

   das_pingpong_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clk   (s00_axis_aclk),
      .i_rst_n (s00_axis_aresetn),
      .i_we    (w_store),
      .i_waddr ({r_wr_bank, r_wr_addr}),
      .i_wdata (s00_axis_tdata),
      .i_raddr ({r_rd_bank, rd_addr}),
      .o_rdata (rd_data)
   );

endmodule

// File: tb/tb_das_line_capture.sv
// Scoreboard bench for das_line_capture with 16-sample banks.
module tb_das_line_capture;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int          DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [DATA_W-1:0] s00_axis_tdata = '0;
   logic              s00_axis_tvalid = 1'b0;
   logic              s00_axis_tlast = 1'b0;
   logic              s00_axis_tready;
   logic              line_valid;
   logic [ADDR_W:0]   line_len;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [DATA_W-1:0] rd_data;
   logic              line_done = 1'b0;
   logic [CNT_W-1:0]  line_count;
   logic              err_overflow;
   logic              err_clear = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model state: expected samples and line lengths in write order.
   logic [DATA_W-1:0] sb_data[$];
   int                sb_len[$];
   int                exp_count;
   logic              exp_err;
   int                m_addr;
   bit                m_drop;

   always #5 clk = ~clk;

   das_line_capture #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .s00_axis_tdata   (s00_axis_tdata),
      .s00_axis_tvalid  (s00_axis_tvalid),
      .s00_axis_tlast   (s00_axis_tlast),
      .s00_axis_tready  (s00_axis_tready),
      .line_valid       (line_valid),
      .line_len         (line_len),
      .rd_addr          (rd_addr),
      .rd_data          (rd_data),
      .line_done        (line_done),
      .line_count       (line_count),
      .err_overflow     (err_overflow),
      .err_clear        (err_clear)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      sb_data.delete();
      sb_len.delete();
      exp_count = 0;
      exp_err   = 1'b0;
      m_addr    = 0;
      m_drop    = 1'b0;
   endtask

   task automatic model_accept(input logic [DATA_W-1:0] d, input logic l);
      if (!m_drop) begin
         sb_data.push_back(d);
         m_addr++;
         if (l || m_addr == DEPTH) begin
            sb_len.push_back(m_addr);
            exp_count++;
            if (!l) begin
               m_drop  = 1'b1;
               exp_err = 1'b1;
            end
            m_addr = 0;
         end
      end else if (l) begin
         m_drop = 1'b0;
      end
   endtask

   task automatic drive_beat(input logic [DATA_W-1:0] d, input logic l, input logic done);
      bit acc;
      acc = 1'b0;
      s00_axis_tdata  = d;
      s00_axis_tlast  = l;
      s00_axis_tvalid = 1'b1;
      line_done       = done;
      for (int n = 0; n < 64 && !acc; n++) begin
         acc = s00_axis_tready;
         @(posedge clk); #1;
         line_done = 1'b0;
      end
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL beat_accept data=%h tready=0 required=1", d);
      end else begin
         model_accept(d, l);
      end
   endtask

   task automatic send_line(input int base, input int n, input bit gap, input bit last_end);
      for (int i = 0; i < n; i++) begin
         drive_beat(DATA_W'(base + i), (i == n - 1) && last_end, 1'b0);
         if (gap) begin
            s00_axis_tdata = 32'hDEAD_BEEF;
            s00_axis_tlast = 1'b1;
            @(posedge clk); #1;
            s00_axis_tlast = 1'b0;
         end
      end
   endtask

   task automatic read_line(input bit done);
      int                len;
      logic [DATA_W-1:0] exp;
      checks++;
      if (line_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_valid got=%b exp=1", line_valid);
      end
      if (sb_len.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL read_scoreboard_empty got=empty exp=line");
         return;
      end
      len = sb_len.pop_front();
      checks++;
      if (line_len !== (ADDR_W+1)'(len)) begin
         errors++;
         $display("FAIL line_len got=%0d exp=%0d", line_len, len);
      end
      for (int a = 0; a < len; a++) begin
         rd_addr = ADDR_W'(a);
         @(posedge clk); #1;
         exp = sb_data.pop_front();
         checks++;
         if (rd_data !== exp) begin
            errors++;
            $display("FAIL rd_data addr=%0d got=%h exp=%h", a, rd_data, exp);
         end
      end
      if (done) begin
         line_done = 1'b1;
         @(posedge clk); #1;
         line_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
      line_done       = 1'b0;
      err_clear       = 1'b0;
      rd_addr         = '0;
      rst_n           = 1'b0;
      #2;
      model_reset();
      checks++;
      if (s00_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%b exp=0", s00_axis_tready); end
      checks++;
      if (line_valid !== 1'b0) begin errors++; $display("FAIL rst_line_valid got=%b exp=0", line_valid); end
      checks++;
      if (line_len !== '0) begin errors++; $display("FAIL rst_line_len got=%0d exp=0", line_len); end
      checks++;
      if (line_count !== '0) begin errors++; $display("FAIL rst_line_count got=%0d exp=0", line_count); end
      checks++;
      if (err_overflow !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_overflow); end
      checks++;
      if (rd_data !== '0) begin errors++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      checks++;
      if (s00_axis_tready !== 1'b0) begin errors++; $display("FAIL release_tready got=%b exp=0", s00_axis_tready); end
      @(posedge clk); #1;
      checks++;
      if (s00_axis_tready !== 1'b1) begin errors++; $display("FAIL run_tready got=%b exp=1", s00_axis_tready); end
   endtask

   task automatic test_basic();
      send_line(32'h100, 4, 1'b0, 1'b0);
      checks++;
      if (line_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", line_valid); end
      drive_beat(32'h104, 1'b1, 1'b0);
      checks++;
      if (line_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", line_valid); end
      checks++;
      if (line_len !== 5'd5) begin errors++; $display("FAIL basic_len got=%0d exp=5", line_len); end
      checks++;
      if (line_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", line_count, exp_count); end
      rd_addr = 4'd3;
      @(posedge clk); #1;
      checks++;
      if (rd_data !== 32'h103) begin errors++; $display("FAIL basic_rd3 got=%h exp=00000103", rd_data); end
      read_line(1'b1);
   endtask

   task automatic test_backpressure();
      send_line(32'h200, 4, 1'b0, 1'b1);
      send_line(32'h210, 4, 1'b0, 1'b1);
      checks++;
      if (s00_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready_full got=%b exp=0", s00_axis_tready); end
      s00_axis_tdata  = 32'h220;
      s00_axis_tlast  = 1'b0;
      s00_axis_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (s00_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_stall cycle=%0d got=%b exp=0", i, s00_axis_tready); end
      end
      checks++;
      if (line_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", line_count, exp_count); end
      read_line(1'b1);
      checks++;
      if (s00_axis_tready !== 1'b1) begin errors++; $display("FAIL bp_tready_freed got=%b exp=1", s00_axis_tready); end
      send_line(32'h220, 3, 1'b0, 1'b1);
      read_line(1'b1);
      read_line(1'b1);
      checks++;
      if (line_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", line_valid); end
   endtask

   task automatic test_overflow();
      send_line(32'h500, 20, 1'b0, 1'b1);
      checks++;
      if (err_overflow !== exp_err) begin errors++; $display("FAIL ovf_err got=%b exp=%b", err_overflow, exp_err); end
      checks++;
      if (line_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", line_count, exp_count); end
      read_line(1'b1);
      checks++;
      if (line_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_tail_line got=%b exp=0", line_valid); end
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      exp_err   = 1'b0;
      checks++;
      if (err_overflow !== exp_err) begin errors++; $display("FAIL ovf_clear got=%b exp=%b", err_overflow, exp_err); end
      send_line(32'h600, 2, 1'b0, 1'b1);
      checks++;
      if (line_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL ovf_next_count got=%0d exp=%0d", line_count, exp_count); end
      read_line(1'b1);
   endtask

   task automatic test_sparse();
      send_line(32'h700, 6, 1'b1, 1'b1);
      read_line(1'b1);
   endtask

   task automatic test_midline_reset();
      send_line(32'h800, 2, 1'b0, 1'b1);
      send_line(32'h810, 3, 1'b0, 1'b0);
      test_reset();
      send_line(32'h820, 2, 1'b0, 1'b1);
      checks++;
      if (line_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL mid_count got=%0d exp=%0d", line_count, exp_count); end
      read_line(1'b1);
   endtask

   task automatic test_same_cycle();
      send_line(32'h900, 3, 1'b0, 1'b1);
      read_line(1'b0);
      send_line(32'h910, 4, 1'b0, 1'b0);
      drive_beat(32'h914, 1'b1, 1'b1);
      checks++;
      if (line_valid !== 1'b1) begin errors++; $display("FAIL same_valid got=%b exp=1", line_valid); end
      checks++;
      if (line_len !== 5'd5) begin errors++; $display("FAIL same_len got=%0d exp=5", line_len); end
      checks++;
      if (s00_axis_tready !== 1'b1) begin errors++; $display("FAIL same_tready got=%b exp=1", s00_axis_tready); end
      read_line(1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_sparse();
      test_midline_reset();
      test_same_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/das_line_capture.md
Name: das_line_capture

Overview:
- AXI4-Stream sink that captures beamformed output samples from the DAS beamformer master port into a ping-pong scan-line buffer.
- Each tlast-delimited stream segment is one scan line. A completed line is presented on a random-access read port for the downstream envelope/display stage.
- Backpressure (tready low) is applied only when both banks hold unread lines.

Parameters:
- DATA_W, 32, sample width; matches the beamformer m00_axis_tdata width.
- ADDR_W, 10, line address width; bank depth DEPTH = 2**ADDR_W samples.
- CNT_W, 16, width of the completed-line counter.

Ports:
- s00_axis_aclk, in, 1, single clock for all logic.
- s00_axis_aresetn, in, 1, asynchronous active-low reset.
- s00_axis_tdata, in, DATA_W, beamformed sample.
- s00_axis_tvalid, in, 1, sample valid.
- s00_axis_tlast, in, 1, last sample of a scan line.
- s00_axis_tready, out, 1, sink ready.
- line_valid, out, 1, the read bank holds a complete line.
- line_len, out, ADDR_W+1, sample count of the presented line (1..DEPTH).
- rd_addr, in, ADDR_W, read address into the presented line.
- rd_data, out, DATA_W, registered read data.
- line_done, in, 1, one-cycle pulse: consumer releases the presented line.
- line_count, out, CNT_W, completed lines since reset; wraps.
- err_overflow, out, 1, sticky flag: a line exceeded DEPTH.
- err_clear, in, 1, clears err_overflow.

Behaviour:
- Reset (async assert, synchronous release): wr_bank=0, rd_bank=0, wr_addr=0, full[1:0]=0, drop=0, line_count=0, err_overflow=0, rd_data=0, line_valid=0, line_len=0, tready=0.
- A run flag is cleared by reset and set on the first clock edge after release. tready = run & (drop | ~full[wr_bank]) (combinational from registers).
- Beat accepted when tvalid & tready.
- Accepted beat with drop=0:
  - mem[wr_bank][wr_addr] <= tdata.
  - If tlast or wr_addr==DEPTH-1, the line closes: len[wr_bank] <= wr_addr+1; full[wr_bank] <= 1; wr_bank toggles; wr_addr <= 0; line_count increments.
  - Otherwise wr_addr increments.
- Long line: if a line closes at wr_addr==DEPTH-1 without tlast, then drop <= 1 and err_overflow <= 1. While drop=1, beats are accepted and discarded. An accepted beat with tlast clears drop; no new line starts from the dropped beats.
- Short line: tlast on the first beat gives line_len=1. Zero-length lines cannot occur.
- Read side:
  - line_valid = full[rd_bank]; line_len = len[rd_bank].
  - rd_data <= mem[rd_bank][rd_addr] every cycle: 1-cycle latency.
  - rd_addr >= line_len returns unspecified data (not checked).
- line_done with line_valid=1: full[rd_bank] <= 0, rd_bank toggles. line_done with line_valid=0 is ignored.
- Timing: line_valid rises the cycle after the closing beat is accepted. tready rises the cycle after a line_done that frees the write bank.
- Simultaneous line close and line_done (necessarily on opposite banks): both take effect in the same cycle.
- Ordering: lines are read strictly in write order; the ping-pong guarantees this.
- err_clear has priority over a same-cycle overflow set (flag reads 0 afterwards).
- Reset mid-line discards the partial line and any stored lines.
- Memory: inferred simple dual-port RAM, 2*DEPTH x DATA_W. Write address {wr_bank,wr_addr}; read address {rd_bank,rd_addr}.

Decomposition:
- Shared package das_pkg holds: DATA_W, ADDR_W and CNT_W defaults; the AXIS beat typedef (data, last); the line-length typedef.
- One sub-module, das_pingpong_ram: 2-bank simple dual-port RAM with registered read. The top module holds the write FSM (CAPTURE/DROP via the drop flag), the full flags and the counters.

Test Plan (ADDR_W=4, DEPTH=16):
1. Basic line: 5 beats 0x100..0x104, tlast on 5th -> line_valid=1 the next cycle, line_len=5, line_count=1; rd_addr=3 -> rd_data=0x103 one cycle later.
2. Backpressure: two 4-beat lines, no line_done -> tready=0 after the second tlast and the third line stalls; line_done -> tready=1 next cycle; lines read back in order (first line, then second).
3. Overflow: a 20-beat line (tlast on beat 20) -> line_len=16 holding beats 1..16, err_overflow=1; beats 17..20 accepted and dropped; line_count=1; err_clear -> err_overflow=0.
4. Sparse input: tvalid toggling every other cycle on a 6-beat line -> only handshaken beats stored, line_len=6, data contiguous at addresses 0..5.
5. Mid-line reset: assert reset after 3 beats -> all outputs at reset values; the next 2-beat line lands at addresses 0..1 with line_count=1.
6. Same-cycle events: line_done pulsed in the cycle the second line's closing beat is accepted -> line_valid stays 1, line_len switches to the second line's length, tready stays 1.
